// File: rtl/mips_data_mem_responder_pkg.sv
// Shared types and helpers for the CPU data-memory responder slice.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_t;

    localparam int unsigned WAIT_CNT_W = 4;

    // Lane-wise merge: bit i of be selects new_word byte i over old_word byte i.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/mips_data_mem_responder_if.sv
// Harvard data-memory port between the CPU (master) and the memory responder (slave).
interface mips_data_mem_responder_if;

    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [3:0]  data_byteenable;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    modport master (
        output data_address, data_read, data_write, data_byteenable, data_writedata,
        input  data_readdata
    );

    modport slave (
        input  data_address, data_read, data_write, data_byteenable, data_writedata,
        output data_readdata
    );

endinterface

// File: rtl/mips_data_mem_responder_word_ram.sv
// Single-port word RAM: synchronous read, 4-lane byte write, combinational read tap.
module mips_word_ram
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter              INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [31:0]           wdata,
    input  logic                  re,
    output logic [31:0]           rdata,
    output logic [31:0]           rdata_comb
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= merge_bytes(mem[addr], wdata, be);
        if (re) rdata <= mem[addr];
    end

    assign rdata_comb = mem[addr];

endmodule

// File: rtl/mips_data_mem_responder.sv
// Slow word-RAM responder for the CPU data port; stalls the CPU via clk_enable per access.
module mips_data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter              INIT_FILE   = ""
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable_in,
    output logic                        clk_enable,
    output logic                        busy,
    output logic                        err_sticky,
    mips_data_mem_responder_if.slave    bus
);

    if (WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be 0..15 to fit the 4-bit counter");
    end
    if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
        $error("BASE_ADDR must be word aligned");
    end
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 29) begin : g_bad_aw
        $error("ADDR_WIDTH must be 1..29");
    end

    localparam logic [WAIT_CNT_W-1:0] LOAD_CNT =
        WAIT_CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    mem_state_t              state;
    logic [WAIT_CNT_W-1:0]   counter;
    logic                    resp_valid_q;

    logic [31:0]             offset;
    logic                    in_range;
    logic [ADDR_WIDTH-1:0]   index;
    logic                    req;
    logic                    rd_only;
    logic                    stall;
    logic                    go_resp;
    logic                    ram_we;
    logic                    ram_re;
    logic [31:0]             ram_rdata;
    logic [31:0]             ram_rdata_comb;
    logic                    unused_lsbs;

    assign req         = bus.data_read | bus.data_write;
    assign rd_only     = bus.data_read & ~bus.data_write;
    assign offset      = bus.data_address - BASE_ADDR;
    assign in_range    = (bus.data_address >= BASE_ADDR) && (offset[31:ADDR_WIDTH+2] == '0);
    assign index       = offset[ADDR_WIDTH+1:2];
    assign unused_lsbs = ^offset[1:0];

    // The request cycle itself is the first stall cycle, so WAIT lasts
    // WAIT_CYCLES-1 cycles and the counter holds the WAIT cycles remaining.
    always_comb begin
        stall   = 1'b0;
        go_resp = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:    stall = req && (WAIT_CYCLES != 0);
                WAIT:    stall = 1'b1;
                default: stall = 1'b0;
            endcase
            if (req) begin
                if (state == IDLE && WAIT_CYCLES != 0 && LOAD_CNT == '0) go_resp = 1'b1;
                if (state == WAIT && counter == WAIT_CNT_W'(1))          go_resp = 1'b1;
            end
        end
    end

    assign ram_re     = go_resp && rd_only && in_range;
    assign ram_we     = !reset && enable_in && bus.data_write && in_range &&
                        ((WAIT_CYCLES == 0 && state == IDLE) || state == RESP);
    assign clk_enable = enable_in & ~stall;
    assign busy       = (state == WAIT);

    always_comb begin
        bus.data_readdata = '0;
        case (state)
            IDLE:    if (WAIT_CYCLES == 0 && rd_only && in_range) bus.data_readdata = ram_rdata_comb;
            RESP:    if (resp_valid_q) bus.data_readdata = ram_rdata;
            default: bus.data_readdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            counter      <= '0;
            resp_valid_q <= 1'b0;
            err_sticky   <= 1'b0;
        end else begin
            if (state == IDLE && req && (!in_range || (bus.data_read && bus.data_write)))
                err_sticky <= 1'b1;
            case (state)
                IDLE: begin
                    if (req && WAIT_CYCLES != 0) begin
                        counter <= LOAD_CNT;
                        if (go_resp) begin
                            state        <= RESP;
                            resp_valid_q <= ram_re;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!req) begin
                        state   <= IDLE;
                        counter <= '0;
                    end else begin
                        counter <= counter - 1'b1;
                        if (go_resp) begin
                            state        <= RESP;
                            resp_valid_q <= ram_re;
                        end
                    end
                end
                RESP: begin
                    if (enable_in) begin
                        state        <= IDLE;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mips_word_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clk        (clk),
        .addr       (index),
        .we         (ram_we),
        .be         (bus.data_byteenable),
        .wdata      (bus.data_writedata),
        .re         (ram_re),
        .rdata      (ram_rdata),
        .rdata_comb (ram_rdata_comb)
    );

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Scoreboard bench: a 2-wait-state and a zero-wait responder driven as a CPU would.
module tb_mips_data_mem_responder;

    logic clk = 1'b0;
    logic reset;
    logic enable_in;
    logic clk_enable2, busy2, err2;
    logic clk_enable0, busy0, err0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mdl2 [int unsigned];
    logic [31:0] mdl0 [int unsigned];
    logic [31:0] rd_q [$];

    mips_data_mem_responder_if bus2();
    mips_data_mem_responder_if bus0();

    mips_data_mem_responder #(
        .ADDR_WIDTH (10), .BASE_ADDR (32'h0000_1000), .WAIT_CYCLES (2), .INIT_FILE ("")
    ) dut2 (
        .clk (clk), .reset (reset), .enable_in (enable_in), .clk_enable (clk_enable2),
        .busy (busy2), .err_sticky (err2), .bus (bus2.slave)
    );

    mips_data_mem_responder #(
        .ADDR_WIDTH (10), .BASE_ADDR (32'h0000_1000), .WAIT_CYCLES (0), .INIT_FILE ("")
    ) dut0 (
        .clk (clk), .reset (reset), .enable_in (enable_in), .clk_enable (clk_enable0),
        .busy (busy0), .err_sticky (err0), .bus (bus0.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= 32'h1000) && (a < 32'h2000);
    endfunction

    function automatic int unsigned widx(input logic [31:0] a);
        return (a - 32'h1000) >> 2;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] wd,
                                               input logic [3:0] be);
        return {be[3] ? wd[31:24] : old_w[31:24], be[2] ? wd[23:16] : old_w[23:16],
                be[1] ? wd[15:8]  : old_w[15:8],  be[0] ? wd[7:0]   : old_w[7:0]};
    endfunction

    task automatic drive_bus(input bit zw, input logic rd, input logic wr, input logic [31:0] a,
                             input logic [3:0] be, input logic [31:0] wd);
        if (zw) begin
            bus0.data_read = rd; bus0.data_write = wr; bus0.data_address = a;
            bus0.data_byteenable = be; bus0.data_writedata = wd;
        end else begin
            bus2.data_read = rd; bus2.data_write = wr; bus2.data_address = a;
            bus2.data_byteenable = be; bus2.data_writedata = wd;
        end
    endtask

    task automatic bus_idle();
        drive_bus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive_bus(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    // Called at posedge+1; leaves the request asserted so calls run back to back.
    task automatic do_access(input bit zw, input logic rd, input logic wr, input logic [31:0] a,
                             input logic [3:0] be, input logic [31:0] wd, input string name);
        int          stalls = 0;
        bit          done = 0;
        logic [31:0] got, exp_d, old_w;
        logic        ce;
        int unsigned ix;
        ix = widx(a);
        if (rd) begin
            if (wr || !in_rng(a)) rd_q.push_back(32'h0);
            else rd_q.push_back(zw ? mdl0[ix] : mdl2[ix]);
        end
        drive_bus(zw, rd, wr, a, be, wd);
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            #2;
            ce  = zw ? clk_enable0 : clk_enable2;
            got = zw ? bus0.data_readdata : bus2.data_readdata;
            if (ce === 1'b1) begin
                done = 1;
                if (rd) begin
                    exp_d = rd_q.pop_front();
                    checks++;
                    if (got !== exp_d) begin
                        errors++;
                        $display("FAIL %s rdata: got %h expected %h", name, got, exp_d);
                    end
                end
                if (wr && in_rng(a)) begin
                    old_w = zw ? mdl0[ix] : mdl2[ix];
                    if (zw) mdl0[ix] = lane_merge(old_w, wd, be);
                    else    mdl2[ix] = lane_merge(old_w, wd, be);
                end
            end else begin
                stalls++;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s handshake: clk_enable never returned high within 20 cycles", name);
        end
        checks++;
        if (stalls != (zw ? 0 : 2)) begin
            errors++;
            $display("FAIL %s stalls: got %0d expected %0d", name, stalls, zw ? 0 : 2);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable_in = 1'b1; bus_idle();
        repeat (2) @(posedge clk);
        #1;
        drive_bus(1'b0, 1'b1, 1'b0, 32'h1000, 4'hF, 32'h0);
        #2;
        checks++;
        if (clk_enable2 !== 1'b1) begin errors++; $display("FAIL reset_ce2: got %b expected 1", clk_enable2); end
        checks++;
        if (clk_enable0 !== 1'b1) begin errors++; $display("FAIL reset_ce0: got %b expected 1", clk_enable0); end
        @(posedge clk); #1;
        reset = 1'b0; bus_idle();
        #2;
        checks++;
        if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy2: got %b expected 0", busy2); end
        checks++;
        if (err2 !== 1'b0) begin errors++; $display("FAIL reset_err2: got %b expected 0", err2); end
        checks++;
        if (bus2.data_readdata !== 32'h0) begin errors++; $display("FAIL reset_rdata2: got %h expected 0", bus2.data_readdata); end
        checks++;
        if (err0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL reset_dut0: got err %b busy %b expected 0 0", err0, busy0); end
        @(posedge clk); #1;
    endtask

    task automatic test_sw_lw();
        do_access(1'b0, 1'b0, 1'b1, 32'h1000, 4'hF, 32'hDEADBEEF, "sw_1000");
        do_access(1'b0, 1'b1, 1'b0, 32'h1000, 4'hF, 32'h0,        "lw_1000");
        bus_idle(); @(posedge clk); #1;
    endtask

    task automatic test_byte_merge(input bit zw);
        do_access(zw, 1'b0, 1'b1, 32'h1004, 4'hF,    32'h11223344, "sw_1004");
        do_access(zw, 1'b0, 1'b1, 32'h1004, 4'b0100, 32'h00AA0000, "sb_1004");
        do_access(zw, 1'b1, 1'b0, 32'h1004, 4'hF,    32'h0,        "lw_1004");
        do_access(zw, 1'b0, 1'b1, 32'h1008, 4'hF,    32'h55667788, "sw_1008");
        do_access(zw, 1'b0, 1'b1, 32'h1008, 4'b1100, 32'hBEEF0000, "sh_1008");
        do_access(zw, 1'b1, 1'b0, 32'h1008, 4'hF,    32'h0,        "lw_1008");
        do_access(zw, 1'b0, 1'b1, 32'h1008, 4'h0,    32'hFFFFFFFF, "sw_be0");
        do_access(zw, 1'b1, 1'b0, 32'h1008, 4'hF,    32'h0,        "lw_be0");
        bus_idle(); @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        do_access(1'b0, 1'b0, 1'b1, 32'h1FFC, 4'hF, 32'hA5A5_0001, "b2b_sw_top");
        do_access(1'b0, 1'b1, 1'b0, 32'h1FFC, 4'hF, 32'h0,         "b2b_lw_top");
        do_access(1'b0, 1'b1, 1'b0, 32'h1004, 4'hF, 32'h0,         "b2b_lw_1004");
        do_access(1'b0, 1'b1, 1'b0, 32'h1000, 4'hF, 32'h0,         "b2b_lw_1000");
        bus_idle(); @(posedge clk); #1;
    endtask

    task automatic test_resp_hold();
        logic [31:0] held;
        do_access(1'b0, 1'b0, 1'b1, 32'h1010, 4'hF, 32'h01010101, "hold_pre");
        drive_bus(1'b0, 1'b0, 1'b1, 32'h1010, 4'hF, 32'h0BADF00D);
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++;
            if (clk_enable2 !== 1'b0) begin errors++; $display("FAIL hold_stall%0d: got ce %b expected 0", i, clk_enable2); end
            @(posedge clk); #1;
        end
        enable_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (busy2 !== 1'b0 || clk_enable2 !== 1'b0) begin
                errors++; $display("FAIL hold_resp%0d: got busy %b ce %b expected 0 0", i, busy2, clk_enable2);
            end
            @(posedge clk); #1;
            held = dut2.u_ram.mem[4];
            checks++;
            if (held !== 32'h01010101) begin errors++; $display("FAIL hold_nocommit%0d: got %h expected 01010101", i, held); end
        end
        enable_in = 1'b1;
        #2;
        checks++;
        if (clk_enable2 !== 1'b1) begin errors++; $display("FAIL hold_release: got ce %b expected 1", clk_enable2); end
        @(posedge clk); #1;
        mdl2[4] = 32'h0BADF00D;
        do_access(1'b0, 1'b1, 1'b0, 32'h1010, 4'hF, 32'h0, "hold_lw");
        bus_idle(); @(posedge clk); #1;
    endtask

    task automatic test_out_of_range();
        #2;
        checks++;
        if (err2 !== 1'b0) begin errors++; $display("FAIL oor_err_before: got %b expected 0", err2); end
        @(posedge clk); #1;
        do_access(1'b0, 1'b1, 1'b0, 32'h0000_0FFC, 4'hF, 32'h0, "oor_lw_below");
        bus_idle(); #2;
        checks++;
        if (err2 !== 1'b1) begin errors++; $display("FAIL oor_err_set: got %b expected 1", err2); end
        @(posedge clk); #1;
        do_access(1'b0, 1'b0, 1'b1, 32'h2000, 4'hF, 32'hFFFF_FFFF, "oor_sw_above");
        do_access(1'b0, 1'b1, 1'b0, 32'h1000, 4'hF, 32'h0,         "oor_ram_intact");
        do_access(1'b0, 1'b1, 1'b1, 32'h100C, 4'hF, 32'h12345678,  "rdwr_both");
        do_access(1'b0, 1'b1, 1'b0, 32'h100C, 4'hF, 32'h0,         "rdwr_lw");
        bus_idle();
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (err2 !== 1'b1) begin errors++; $display("FAIL oor_err_sticky: got %b expected 1", err2); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_wait();
        drive_bus(1'b0, 1'b0, 1'b1, 32'h1000, 4'hF, 32'hCAFEF00D);
        @(posedge clk); #1;
        reset = 1'b1;
        #2;
        checks++;
        if (busy2 !== 1'b1) begin errors++; $display("FAIL rst_wait_busy: got %b expected 1", busy2); end
        checks++;
        if (clk_enable2 !== enable_in) begin errors++; $display("FAIL rst_wait_ce: got %b expected %b", clk_enable2, enable_in); end
        @(posedge clk); #1;
        reset = 1'b0; bus_idle();
        #2;
        checks++;
        if (busy2 !== 1'b0 || clk_enable2 !== 1'b1) begin
            errors++; $display("FAIL rst_wait_idle: got busy %b ce %b expected 0 1", busy2, clk_enable2);
        end
        checks++;
        if (err2 !== 1'b0) begin errors++; $display("FAIL rst_wait_err: got %b expected 0", err2); end
        @(posedge clk); #1;
        do_access(1'b0, 1'b1, 1'b0, 32'h1000, 4'hF, 32'h0, "rst_wait_lw");
        bus_idle(); @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_byte_merge(1'b0);
        test_byte_merge(1'b1);
        test_back_to_back();
        test_resp_hold();
        test_out_of_range();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
